cgra_config_sequencer: RTL

Hardware sequencer that drives the CGRA Interconnect configuration bus (`config_*` and `stall`) from a stream of commands. It replaces hand-driven configuration sequences: bitstream write, readback-verify, SRAM prefill and readback over config, stall/unstall, and the flush-pulse protocol. It sits between the host/SoC command source and the Interconnect config ports. One instance drives all `config_N_*` copies and all `stall` bits.

---
 rtl/cgra_cfg_pkg.sv | 33 +++
 rtl/cgra_cfg_timer.sv | 38 +++
 rtl/cgra_config_sequencer.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/cgra_cfg_pkg.sv
// Shared types and constants for the CGRA configuration sequencer.
//   cfg_op_e    : command opcodes carried on cmd_op (5..7 decode as NOP)
//   cfg_state_e : sequencer FSM states
//   *_DEF       : default flush-tile address/data and flush length
//   STALL_ALL   : all-ones stall pattern, sliced to the instance stall width
package cgra_cfg_pkg;

    typedef enum logic [2:0] {
        OP_WRITE  = 3'd0,
        OP_VERIFY = 3'd1,
        OP_READ   = 3'd2,
        OP_RUN    = 3'd3,
        OP_HALT   = 3'd4
    } cfg_op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR,
        ST_RD,
        ST_FL_ON,
        ST_FL_GAP,
        ST_FL_OFF
    } cfg_state_e;

    localparam logic [31:0] FLUSH_ADDR_DEF = 32'h0000_0204;
    localparam logic [31:0] FLUSH_ON_DEF   = 32'h001C_7E00;
    localparam logic [31:0] FLUSH_OFF_DEF  = 32'h001C_0000;
    localparam int unsigned FLUSH_LEN_DEF  = 2;

    localparam int unsigned STALL_W_MAX = 32;
    localparam logic [STALL_W_MAX-1:0] STALL_ALL = '1;

endpackage

// File: rtl/cgra_cfg_timer.sv
// 4-bit loadable down-counter shared by the read-hold and flush-assert phases.
//   clk_i, rst_ni : clock, async active-low reset
//   load_i        : load load_val_i (takes priority over dec_i)
//   load_val_i    : remaining cycles minus one
//   dec_i         : decrement while nonzero
//   done_o        : counter is zero (current cycle is the last of the phase)
module cgra_cfg_timer (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       load_i,
    input  logic [3:0] load_val_i,
    input  logic       dec_i,
    output logic       done_o
);

    logic [3:0] count_q;
    logic [3:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (dec_i && (count_q != 4'd0)) begin
            count_d = count_q - 4'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign done_o = (count_q == 4'd0);

endmodule

// File: rtl/cgra_config_sequencer.sv
// Command-driven sequencer for the CGRA Interconnect configuration bus.
// Translates WRITE / VERIFY / READ / RUN / HALT commands into config bus
// strobe sequences, stall control and the flush-pulse protocol.
//   clk, reset_n            : clock, async active-low reset
//   cmd_valid/cmd_ready     : command handshake (ready only in IDLE)
//   cmd_op/cmd_addr/cmd_data: opcode, config address, write/expected data
//   rsp_valid/rsp_data      : one-cycle READ result
//   err_clr                 : clears err_count/err_addr (wins over a mismatch)
//   err_count/err_addr      : saturating VERIFY mismatch count, last bad address
//   busy                    : FSM not in IDLE
//   config_*                : registered config bus address/data/strobes
//   stall                   : CGRA stall bits (all ones = configuration mode)
//   read_config_data        : config bus read data
module cgra_config_sequencer
    import cgra_cfg_pkg::*;
#(
    parameter int unsigned READ_LAT   = 1,
    parameter int unsigned STALL_W    = 4,
    parameter logic [31:0] FLUSH_ADDR = FLUSH_ADDR_DEF,
    parameter logic [31:0] FLUSH_ON   = FLUSH_ON_DEF,
    parameter logic [31:0] FLUSH_OFF  = FLUSH_OFF_DEF,
    parameter int unsigned FLUSH_LEN  = FLUSH_LEN_DEF
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [2:0]         cmd_op,
    input  logic [31:0]        cmd_addr,
    input  logic [31:0]        cmd_data,
    output logic               rsp_valid,
    output logic [31:0]        rsp_data,
    input  logic               err_clr,
    output logic [15:0]        err_count,
    output logic [31:0]        err_addr,
    output logic               busy,
    output logic [31:0]        config_config_addr,
    output logic [31:0]        config_config_data,
    output logic               config_read,
    output logic               config_write,
    output logic [STALL_W-1:0] stall,
    input  logic [31:0]        read_config_data
);

    localparam logic [STALL_W-1:0] STALL_ONES = STALL_ALL[STALL_W-1:0];

    cfg_state_e         state_q, state_d;
    logic               verify_q, verify_d;
    logic [31:0]        exp_q, exp_d;
    logic [31:0]        cfg_addr_q, cfg_addr_d;
    logic [31:0]        cfg_data_q, cfg_data_d;
    logic               wr_q, wr_d;
    logic               rd_q, rd_d;
    logic [STALL_W-1:0] stall_q, stall_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [31:0]        rsp_data_q, rsp_data_d;
    logic [15:0]        err_count_q, err_count_d;
    logic [31:0]        err_addr_q, err_addr_d;

    logic               mismatch;
    logic               tmr_load;
    logic [3:0]         tmr_load_val;
    logic               tmr_dec;
    logic               tmr_done;

    cgra_cfg_timer u_timer (
        .clk_i      (clk),
        .rst_ni     (reset_n),
        .load_i     (tmr_load),
        .load_val_i (tmr_load_val),
        .dec_i      (tmr_dec),
        .done_o     (tmr_done)
    );

    // Strobes are computed one cycle ahead so every bus output is a flop.
    always_comb begin
        state_d      = state_q;
        verify_d     = verify_q;
        exp_d        = exp_q;
        cfg_addr_d   = cfg_addr_q;
        cfg_data_d   = cfg_data_q;
        wr_d         = 1'b0;
        rd_d         = 1'b0;
        stall_d      = stall_q;
        rsp_valid_d  = 1'b0;
        rsp_data_d   = rsp_data_q;
        err_count_d  = err_count_q;
        err_addr_d   = err_addr_q;
        mismatch     = 1'b0;
        tmr_load     = 1'b0;
        tmr_load_val = '0;
        tmr_dec      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    case (cfg_op_e'(cmd_op))
                        OP_WRITE: begin
                            state_d    = ST_WR;
                            wr_d       = 1'b1;
                            cfg_addr_d = cmd_addr;
                            cfg_data_d = cmd_data;
                        end
                        OP_VERIFY, OP_READ: begin
                            state_d      = ST_RD;
                            rd_d         = 1'b1;
                            cfg_addr_d   = cmd_addr;
                            verify_d     = (cfg_op_e'(cmd_op) == OP_VERIFY);
                            exp_d        = cmd_data;
                            tmr_load     = 1'b1;
                            tmr_load_val = 4'(READ_LAT - 1);
                        end
                        OP_RUN: begin
                            state_d      = ST_FL_ON;
                            stall_d      = '0;
                            wr_d         = 1'b1;
                            cfg_addr_d   = FLUSH_ADDR;
                            cfg_data_d   = FLUSH_ON;
                            tmr_load     = 1'b1;
                            tmr_load_val = 4'(FLUSH_LEN - 1);
                        end
                        OP_HALT: begin
                            stall_d = STALL_ONES;
                        end
                        default: ;
                    endcase
                end
            end
            ST_WR: begin
                state_d = ST_IDLE;
            end
            ST_RD: begin
                if (tmr_done) begin
                    state_d = ST_IDLE;
                    if (verify_q) begin
                        mismatch = (read_config_data != exp_q);
                    end else begin
                        rsp_valid_d = 1'b1;
                        rsp_data_d  = read_config_data;
                    end
                end else begin
                    rd_d    = 1'b1;
                    tmr_dec = 1'b1;
                end
            end
            ST_FL_ON: begin
                if (tmr_done) begin
                    state_d = ST_FL_GAP;
                end else begin
                    wr_d    = 1'b1;
                    tmr_dec = 1'b1;
                end
            end
            ST_FL_GAP: begin
                state_d    = ST_FL_OFF;
                wr_d       = 1'b1;
                cfg_data_d = FLUSH_OFF;
            end
            ST_FL_OFF: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A clear on the same edge as a mismatch leaves the counter at zero.
        if (err_clr) begin
            err_count_d = '0;
            err_addr_d  = '0;
        end else if (mismatch) begin
            if (err_count_q != '1) begin
                err_count_d = err_count_q + 16'd1;
            end
            err_addr_d = cfg_addr_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            verify_q    <= 1'b0;
            exp_q       <= '0;
            cfg_addr_q  <= '0;
            cfg_data_q  <= '0;
            wr_q        <= 1'b0;
            rd_q        <= 1'b0;
            stall_q     <= STALL_ONES;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            err_count_q <= '0;
            err_addr_q  <= '0;
        end else begin
            state_q     <= state_d;
            verify_q    <= verify_d;
            exp_q       <= exp_d;
            cfg_addr_q  <= cfg_addr_d;
            cfg_data_q  <= cfg_data_d;
            wr_q        <= wr_d;
            rd_q        <= rd_d;
            stall_q     <= stall_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            err_count_q <= err_count_d;
            err_addr_q  <= err_addr_d;
        end
    end

    assign cmd_ready          = (state_q == ST_IDLE);
    assign busy               = (state_q != ST_IDLE);
    assign config_config_addr = cfg_addr_q;
    assign config_config_data = cfg_data_q;
    assign config_write       = wr_q;
    assign config_read        = rd_q;
    assign stall              = stall_q;
    assign rsp_valid          = rsp_valid_q;
    assign rsp_data           = rsp_data_q;
    assign err_count          = err_count_q;
    assign err_addr           = err_addr_q;

endmodule
